// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// Module      : uart_tx
// Description : UART transmitter. Sends a start bit, DBIT data bits (LSB first),
//               an optional even-parity bit and a stop period of SB_TICK
//               oversampling ticks. Each bit lasts 16 s_tick pulses.
// Build macro : UART_TX_PARITY_EN - when defined, a PARITY state between DATA
//               and STOP drives the even-parity bit of the latched data.
// Ports       :
//   clk          in   system clock, rising edge
//   reset        in   synchronous reset, active low
//   s_tick       in   16x oversampling enable, one clk wide
//   tx_start     in   request to send din (accepted only in IDLE)
//   din          in   DBIT-wide data word, latched on acceptance
//   tx           out  registered serial line, idle high
//   tx_busy      out  high whenever the FSM is not in IDLE
//   tx_done_tick out  one-cycle pulse on the edge that ends the stop period
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // Bit counter wide enough for DBIT-1; tick counter is 4 bits for the
    // 16-tick bit cells and grows only if the stop period needs more.
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [TW-1:0] TICK_BIT_LAST  = TW'(15);
    localparam logic [TW-1:0] TICK_STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST       = BW'(DBIT - 1);

    logic [2:0]      state_q, state_d;
    logic [TW-1:0]   tick_q,  tick_d;
    logic [BW-1:0]   bit_q,   bit_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            tx_q,    tx_d;
    logic            done_d;
    logic [DBIT-1:0] shift_w;
`ifdef UART_TX_PARITY_EN
    // Parity is taken at acceptance because the shift register drains to 0.
    logic            parity_q, parity_d;
`endif

    assign shift_w = shreg_q >> 1;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d  = ST_START;
                    tick_d   = '0;
                    bit_d    = '0;
                    shreg_d  = din;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tick_q == TICK_BIT_LAST) begin
                        state_d = ST_DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_BIT_LAST) begin
                        tick_d  = '0;
                        shreg_d = shift_w;
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (tick_q == TICK_BIT_LAST) begin
                        state_d = ST_STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (tick_q == TICK_STOP_LAST) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Output logic: tx is loaded only on bit boundaries, so the registered
    // line never toggles inside a bit cell.
    //--------------------------------------------------------------------------
    always_comb begin
        tx_d   = tx_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    tx_d = 1'b0;
                end
            end
            ST_START: begin
                if (s_tick && (tick_q == TICK_BIT_LAST)) begin
                    tx_d = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (s_tick && (tick_q == TICK_BIT_LAST)) begin
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d = parity_q;
`else
                        tx_d = 1'b1;
`endif
                    end else begin
                        tx_d = shift_w[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick && (tick_q == TICK_BIT_LAST)) begin
                    tx_d = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // Done is flagged in the cycle whose edge ends the stop
                // period; the FSM is still in STOP, so a tx_start seen in
                // this cycle cannot be accepted.
                if (s_tick && (tick_q == TICK_STOP_LAST)) begin
                    done_d = 1'b1;
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != ST_IDLE);
    // A reset on the final edge aborts the frame, so no completion pulse.
    assign tx_done_tick = done_d & reset;

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, stop-bit duration in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; 0 sampled on a rising clk edge resets the block.
REQ-005 s_tick  input  1  oversampling enable from the baud generator, 16 pulses per bit period, one clk cycle wide.
REQ-006 tx_start  input  1  request to send din; accepted only in IDLE.
REQ-007 din  input  DBIT  byte to transmit, sampled on the accepting edge.
REQ-008 tx  output  1  serial line, registered, idle high.
REQ-009 tx_busy  output  1  high in every state except IDLE.
REQ-010 tx_done_tick  output  1  one-clk-cycle pulse marking frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-012 In IDLE with tx_start=1, the next edge SHALL latch din into a shift register, clear the tick and bit counters, enter START and drive tx=0.
REQ-013 tx_start SHALL be ignored in any state other than IDLE, and latched data SHALL NOT change mid-frame when din changes.
REQ-014 s_tick SHALL be ignored in IDLE; the tick counter (4 bits) SHALL increment only on s_tick in the other states.
REQ-015 START SHALL last 16 s_tick pulses; on the edge consuming the 16th pulse, the FSM SHALL enter DATA with tx = shift-register bit 0.
REQ-016 DATA SHALL send DBIT bits LSB first, each lasting 16 s_tick pulses, shifting right on each bit boundary; the bit counter SHALL wrap-check at DBIT-1 with no overflow.
REQ-017 After the last data bit, the FSM SHALL enter STOP with tx=1 (or PARITY when the macro is defined).
REQ-018 STOP SHALL last SB_TICK s_tick pulses; on the edge consuming the last pulse, the FSM SHALL return to IDLE and assert tx_done_tick for exactly that one cycle.
REQ-019 tx_start asserted during the tx_done_tick cycle SHALL be ignored; tx_start held high SHALL be accepted on the first IDLE cycle, giving back-to-back frames with a one-clk idle gap.
REQ-020 The tx line SHALL be glitch-free, changing only on bit boundaries.

Reset
REQ-021 On reset=0 at a rising edge, from any state including mid-frame, the block SHALL enter IDLE with tx=1, tx_busy=0, tx_done_tick=0, all counters 0 and the shift register 0.
REQ-022 A frame interrupted by reset SHALL NOT produce tx_done_tick.
REQ-023 tx_start asserted while reset=0 SHALL be ignored.

Configuration
REQ-024 When macro UART_TX_PARITY_EN is defined, the block SHALL insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of all latched data bits) for 16 s_tick pulses.
REQ-025 When UART_TX_PARITY_EN is undefined, the PARITY state and parity logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-026 Send din=0x55 with DBIT=8 and SB_TICK=16, with an s_tick every 4 clks -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 64 clks; tx_done_tick high exactly one cycle, 640 clks after acceptance.
REQ-027 Pulse tx_start with din=0xA3 in mid-frame of 0x0F -> second request ignored; only 0x0F appears on tx; one tx_done_tick.
REQ-028 Assert reset=0 during data bit 3 of 0xFF -> tx=1, tx_busy=0 on the next edge; no tx_done_tick; a new frame of 0x01 afterwards is correct.
REQ-029 Hold tx_start=1 with din=0x80 then 0x7E -> two consecutive frames separated by one idle clk; two tx_done_tick pulses.
REQ-030 With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 before stop; send 0x03 -> parity bit 0; without the macro, the frame is 10 bits.
